// File: rtl/alien_pkg.sv
// Shared constants and types for the alien bomb launcher.
// Sprite geometry, bomb geometry, LFSR constants and the launcher FSM states.
package alien_pkg;

    localparam int unsigned ALIEN_WIDTH  = 16;
    localparam int unsigned ALIEN_HEIGHT = 8;
    localparam int unsigned BOMB_WIDTH   = 1;
    localparam int unsigned BOMB_HEIGHT  = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_FLIGHT = 2'd2
    } bomb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alien_bomb_launcher_if.sv
// Formation/scan inputs and bomb outputs of the alien bomb launcher.
// master: the surrounding game logic; slave: the launcher itself.
interface alien_bomb_launcher_if
    import alien_pkg::*;
#(
    parameter int unsigned NUM_ROWS    = 2,
    parameter int unsigned NUM_COLUMNS = 4
);
    localparam int unsigned COL_W = idx_width(NUM_COLUMNS);

    logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] alive_matrix;
    logic [15:0]                          origin_x;
    logic [15:0]                          origin_y;
    logic                                 frame_tick;
    logic                                 bomb_hit;
    logic [15:0]                          scan_x;
    logic [15:0]                          scan_y;
    logic                                 bomb_active;
    logic [15:0]                          bomb_x;
    logic [15:0]                          bomb_y;
    logic [COL_W-1:0]                     bomb_column;
    logic                                 bomb_pixel;

    modport master (
        output alive_matrix, origin_x, origin_y, frame_tick, bomb_hit, scan_x, scan_y,
        input  bomb_active, bomb_x, bomb_y, bomb_column, bomb_pixel
    );

    modport slave (
        input  alive_matrix, origin_x, origin_y, frame_tick, bomb_hit, scan_x, scan_y,
        output bomb_active, bomb_x, bomb_y, bomb_column, bomb_pixel
    );

endinterface

// File: rtl/alien_bomb_launcher_lfsr16.sv
// 16-bit Galois LFSR, free-running every clock from LFSR_SEED.
module lfsr16
    import alien_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // Shift right, folding the taps in when a one falls out of bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LFSR_SEED;
        end else if (r_state[0]) begin
            r_state <= (r_state >> 1) ^ LFSR_TAPS;
        end else begin
            r_state <= r_state >> 1;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/alien_bomb_launcher.sv
// Alien return-fire stage: picks a pseudo-random firing column, launches a
// bomb from its lowest living alien and drops it once per frame.
// Optional feature: define ALIEN_BOMB_ZIGZAG_EN to wobble bomb_x by
// +/-SCALING on every flight frame (first step +).
module alien_bomb_launcher
    import alien_pkg::*;
#(
    parameter int unsigned NUM_ROWS        = 2,
    parameter int unsigned NUM_COLUMNS     = 4,
    parameter int unsigned ALIEN_SPACING_X = 40,
    parameter int unsigned ALIEN_SPACING_Y = 40,
    parameter int unsigned SCALING         = 2,
    parameter int unsigned MAX_POSITION_Y  = 480,
    parameter int unsigned FIRE_INTERVAL   = 60,
    parameter int unsigned BOMB_SPEED      = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    alien_bomb_launcher_if.slave  bus
);

    localparam int unsigned COL_W = idx_width(NUM_COLUMNS);
    localparam int unsigned ROW_W = idx_width(NUM_ROWS);
    localparam int unsigned CD_W  = $clog2(FIRE_INTERVAL + 1);

    localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(FIRE_INTERVAL);
    localparam logic [CD_W-1:0]  CD_ONE    = CD_W'(1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLUMNS - 1);
    localparam logic [15:0]      COL_MASK  = 16'((1 << COL_W) - 1);
    localparam logic [15:0]      NCOL16    = 16'(NUM_COLUMNS);
    localparam logic [15:0]      HALF_W    = 16'(ALIEN_WIDTH * SCALING / 2);
    localparam logic [15:0]      FULL_H    = 16'(ALIEN_HEIGHT * SCALING);
    localparam logic [15:0]      PITCH_X   = 16'(ALIEN_SPACING_X);
    localparam logic [15:0]      PITCH_Y   = 16'(ALIEN_SPACING_Y);
    localparam logic [16:0]      SPEED17   = 17'(BOMB_SPEED);
    localparam logic [16:0]      MAX17     = 17'(MAX_POSITION_Y);
    localparam logic [16:0]      BOMB_W17  = 17'(BOMB_WIDTH * SCALING);
    localparam logic [16:0]      BOMB_H17  = 17'(BOMB_HEIGHT * SCALING);
`ifdef ALIEN_BOMB_ZIGZAG_EN
    localparam logic [15:0]      ZIG_STEP  = 16'(SCALING);
`endif

    bomb_state_t      r_state;
    logic [CD_W-1:0]  r_cooldown;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] r_scan_cnt;
    logic             r_bomb_active;
    logic [15:0]      r_bomb_x;
    logic [15:0]      r_bomb_y;
    logic [COL_W-1:0] r_bomb_column;
    logic             r_bomb_pixel;
`ifdef ALIEN_BOMB_ZIGZAG_EN
    logic             r_zig_neg;
`endif

    logic [15:0]      w_lfsr;
    logic [15:0]      w_start_raw;
    logic [COL_W-1:0] w_start_col;
    logic             w_col_alive;
    logic [ROW_W-1:0] w_row;
    logic [15:0]      w_launch_x;
    logic [15:0]      w_launch_y;
    logic [16:0]      w_next_y;

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    // Folded LFSR low bits give the first column to examine.
    assign w_start_raw = w_lfsr & COL_MASK;
    assign w_start_col = COL_W'((w_start_raw >= NCOL16) ? (w_start_raw - NCOL16) : w_start_raw);

    // Column under examination: any alive, and the highest-index alive row.
    always_comb begin
        w_col_alive = 1'b0;
        w_row       = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (bus.alive_matrix[r][r_col]) begin
                w_col_alive = 1'b1;
                w_row       = ROW_W'(r);
            end
        end
    end

    // Launch point below the chosen alien, and the next flight row (17 bits so it never wraps).
    assign w_launch_x = bus.origin_x + (16'(r_col) * PITCH_X) + HALF_W;
    assign w_launch_y = bus.origin_y + (16'(w_row) * PITCH_Y) + FULL_H;
    assign w_next_y   = {1'b0, r_bomb_y} + SPEED17;

    // Launcher FSM: cooldown in IDLE, column search in SELECT, descent in FLIGHT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cooldown    <= CD_RELOAD;
            r_col         <= '0;
            r_scan_cnt    <= '0;
            r_bomb_active <= 1'b0;
            r_bomb_x      <= '0;
            r_bomb_y      <= '0;
            r_bomb_column <= '0;
`ifdef ALIEN_BOMB_ZIGZAG_EN
            r_zig_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_tick) begin
                        if (r_cooldown <= CD_ONE) begin
                            r_cooldown <= '0;
                            r_col      <= w_start_col;
                            r_scan_cnt <= '0;
                            r_state    <= ST_SELECT;
                        end else begin
                            r_cooldown <= r_cooldown - CD_ONE;
                        end
                    end
                end
                ST_SELECT: begin
                    if (w_col_alive) begin
                        r_bomb_x      <= w_launch_x;
                        r_bomb_y      <= w_launch_y;
                        r_bomb_column <= r_col;
                        r_bomb_active <= 1'b1;
`ifdef ALIEN_BOMB_ZIGZAG_EN
                        r_zig_neg     <= 1'b0;
`endif
                        r_state       <= ST_FLIGHT;
                    end else if (r_scan_cnt == LAST_COL) begin
                        r_cooldown <= CD_RELOAD;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_col      <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
                        r_scan_cnt <= r_scan_cnt + COL_W'(1);
                    end
                end
                ST_FLIGHT: begin
                    if (bus.bomb_hit) begin
                        r_bomb_active <= 1'b0;
                        r_cooldown    <= CD_RELOAD;
                        r_state       <= ST_IDLE;
                    end else if (bus.frame_tick) begin
                        r_bomb_y <= w_next_y[15:0];
`ifdef ALIEN_BOMB_ZIGZAG_EN
                        r_bomb_x  <= r_zig_neg ? (r_bomb_x - ZIG_STEP) : (r_bomb_x + ZIG_STEP);
                        r_zig_neg <= ~r_zig_neg;
`else
                        r_bomb_x <= r_bomb_x;
`endif
                        if (w_next_y >= MAX17) begin
                            r_bomb_active <= 1'b0;
                            r_cooldown    <= CD_RELOAD;
                            r_state       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_bomb_active <= 1'b0;
                    r_cooldown    <= CD_RELOAD;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Bomb rectangle hit test against the scan position, one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bomb_pixel <= 1'b0;
        end else begin
            r_bomb_pixel <= r_bomb_active
                         && (bus.scan_x >= r_bomb_x)
                         && ({1'b0, bus.scan_x} < ({1'b0, r_bomb_x} + BOMB_W17))
                         && (bus.scan_y >= r_bomb_y)
                         && ({1'b0, bus.scan_y} < ({1'b0, r_bomb_y} + BOMB_H17));
        end
    end

    assign bus.bomb_active = r_bomb_active;
    assign bus.bomb_x      = r_bomb_x;
    assign bus.bomb_y      = r_bomb_y;
    assign bus.bomb_column = r_bomb_column;
    assign bus.bomb_pixel  = r_bomb_pixel;

endmodule

// File: tb/tb_alien_bomb_launcher.sv
// Scoreboard bench for alien_bomb_launcher (default parameters).
// Launch expectations are queued by the stimulus and checked by a monitor
// when bomb_active rises. Honours ALIEN_BOMB_ZIGZAG_EN for bomb_x.
module tb_alien_bomb_launcher;
    import alien_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alien_bomb_launcher_if #(.NUM_ROWS(2), .NUM_COLUMNS(4)) bus ();

    alien_bomb_launcher #(
        .NUM_ROWS(2), .NUM_COLUMNS(4), .ALIEN_SPACING_X(40), .ALIEN_SPACING_Y(40),
        .SCALING(2), .MAX_POSITION_Y(480), .FIRE_INTERVAL(60), .BOMB_SPEED(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  col;
    } launch_t;

    launch_t exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference Galois LFSR, reset and clocked like the launcher's.
    logic [15:0] m_lfsr;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each launch must match the oldest queued expectation.
    logic prev_active = 1'b0;
    always @(negedge clk) begin
        if (bus.bomb_active && !prev_active) begin
            check("launch_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                launch_t e;
                e = exp_q.pop_front();
                check("launch_x",      32'(bus.bomb_x),      32'(e.x));
                check("launch_y",      32'(bus.bomb_y),      32'(e.y));
                check("launch_column", 32'(bus.bomb_column), 32'(e.col));
            end
        end
        prev_active = bus.bomb_active;
    end

    // One frame_tick pulse; returns the LFSR low bits the DUT samples with it.
    task automatic tick(output logic [1:0] start);
        logic [15:0] s;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        s = m_lfsr;
        start = s[1:0];
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        logic [1:0] dummy;
        for (int i = 0; i < n; i++) tick(dummy);
    endtask

    task automatic wait_launch(output int n);
        n = 0;
        while (!bus.bomb_active && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [15:0] zig_x(input logic [15:0] x0, input int k);
`ifdef ALIEN_BOMB_ZIGZAG_EN
        return (k % 2 == 1) ? x0 + 16'd2 : x0;
`else
        return x0;
`endif
    endfunction

    logic [15:0] pix_x [6] = '{16'd186, 16'd187, 16'd188, 16'd186, 16'd185, 16'd186};
    logic [15:0] pix_y [6] = '{16'd66,  16'd73,  16'd66,  16'd74,  16'd66,  16'd65};
    logic        pix_e [6] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};

    initial begin
        logic [1:0]  s;
        logic [15:0] x0;
        int          n;
        int          k;
        bit          saw;

        rst = 1'b1;
        bus.alive_matrix = '0;
        bus.origin_x = 16'd50;
        bus.origin_y = 16'd50;
        bus.frame_tick = 1'b0;
        bus.bomb_hit = 1'b0;
        bus.scan_x = '0;
        bus.scan_y = '0;
        repeat (3) @(negedge clk);
        check("reset_active", 32'(bus.bomb_active), 32'd0);
        check("reset_pixel",  32'(bus.bomb_pixel),  32'd0);
        check("reset_x",      32'(bus.bomb_x),      32'd0);
        check("reset_y",      32'(bus.bomb_y),      32'd0);
        check("reset_column", 32'(bus.bomb_column), 32'd0);
        rst = 1'b0;

        // All alive: launch from row 1 of the LFSR-chosen column.
        bus.alive_matrix = '1;
        ticks(59);
        check("A_no_early_launch", 32'(bus.bomb_active), 32'd0);
        tick(s);
        x0 = 16'd66 + 16'd40 * 16'(s);
        exp_q.push_back('{x: x0, y: 16'd106, col: s});
        wait_launch(n);
        check("A_latency", 32'(n), 32'd1);

        // Descent until retirement at y = 480.
        k = 0;
        while (bus.bomb_active && k < 250) begin
            tick(s);
            k++;
            if (k <= 4) begin
                check("flight_y", 32'(bus.bomb_y), 32'(106 + 2 * k));
                check("flight_x", 32'(bus.bomb_x), 32'(zig_x(x0, k)));
            end
        end
        check("retire_tick", 32'(k), 32'd187);

        // Single alive alien at [0][3]: search wraps to column 3.
        bus.alive_matrix = '0;
        bus.alive_matrix[0][3] = 1'b1;
        ticks(59);
        check("B_no_early_launch", 32'(bus.bomb_active), 32'd0);
        tick(s);
        exp_q.push_back('{x: 16'd186, y: 16'd66, col: 2'd3});
        wait_launch(n);
        check("B_latency", 32'(n), 32'(((3 - int'(s)) & 3) + 1));

        // Registered pixel hit test around the 2x8 bomb at (186,66).
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.scan_x = pix_x[i];
            bus.scan_y = pix_y[i];
            @(negedge clk);
            check($sformatf("pixel_%0d", i), 32'(bus.bomb_pixel), 32'(pix_e[i]));
        end

        // bomb_hit wins over a simultaneous frame_tick.
        @(negedge clk);
        bus.frame_tick = 1'b1;
        bus.bomb_hit = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.bomb_hit = 1'b0;
        check("hit_active", 32'(bus.bomb_active), 32'd0);
        check("hit_y",      32'(bus.bomb_y),      32'd66);
        check("hit_x",      32'(bus.bomb_x),      32'd186);

        // All dead: search gives up after four columns, then a full reload.
        bus.alive_matrix = '0;
        ticks(60);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.bomb_active) saw = 1'b1;
        end
        bus.alive_matrix = '1;
        repeat (4) begin
            @(negedge clk);
            if (bus.bomb_active) saw = 1'b1;
        end
        check("C_no_launch", 32'(saw), 32'd0);
        ticks(59);
        check("C_reload", 32'(bus.bomb_active), 32'd0);
        tick(s);
        x0 = 16'd66 + 16'd40 * 16'(s);
        exp_q.push_back('{x: x0, y: 16'd106, col: s});
        wait_launch(n);
        check("C_latency", 32'(n), 32'd1);

        // Asynchronous reset mid-flight clears every output.
        @(negedge clk);
        bus.scan_x = x0;
        bus.scan_y = 16'd106;
        @(negedge clk);
        check("pre_reset_pixel", 32'(bus.bomb_pixel), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_active", 32'(bus.bomb_active), 32'd0);
        check("rst_pixel",  32'(bus.bomb_pixel),  32'd0);
        check("rst_x",      32'(bus.bomb_x),      32'd0);
        check("rst_y",      32'(bus.bomb_y),      32'd0);
        check("rst_column", 32'(bus.bomb_column), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
